maxpool_sched: RTL
==================

Name: maxpool_sched

Overview:
Sequencer that feeds the 1D serial maxpool stage. It accepts full-width per-channel samples from the upstream conv layer over a valid/ready handshake and groups them into pairs. Each pair is serialized as SER_BW-bit words, least significant word first, onto the maxpool serial input. It tracks a frame of SEQ_LEN samples, counts maxpool results, and signals frame completion.

Parameters:
NO_CH, 10, channels per sample vector
BW_IN, 12, signed sample width
SER_BW, 4, serial word width; power of two, SER_BW <= BW_IN
SEQ_LEN, 1024, samples per frame; must be even, else elaboration $error
Derived: BUF_CYC = 2 << ($clog2(BW_IN) - $clog2(SER_BW)); HALF = BUF_CYC/2; DATA_SIZE = HALF*SER_BW

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous, active-low reset
in_vld  in  1  upstream sample valid
in_rdy  out  1  scheduler can accept a sample
in_data  in  [NO_CH][BW_IN]  signed sample per channel
mp_vld_in  out  1  serial word valid to maxpool
mp_data_in  out  [NO_CH][SER_BW]  serial word per channel
mp_vld_out  in  1  maxpool result valid, for counting only
frame_done  out  1  one-cycle pulse on the final result of a frame
busy  out  1  high in every state except IDLE
err  out  1  sticky protocol error; see Optional Feature

Behaviour:
- Reset (rst=0, async): state=IDLE; in_rdy=0, mp_vld_in=0, mp_data_in=0, frame_done=0, busy=0, err=0; all counters=0. On deassertion, in_rdy goes high on the first clk edge.
- Handshake: a sample transfers when in_vld && in_rdy on a rising edge. in_rdy is registered and high only in IDLE and WAIT_B.
- States:
  - IDLE: accept on transfer, store as A, go to WAIT_B.
  - WAIT_B: accept on transfer, store as B, drop in_rdy, go to SHIFT with word_cnt=0.
  - SHIFT: mp_vld_in=1 for exactly BUF_CYC consecutive cycles, with no bubbles.
    - word_cnt 0..HALF-1: emit word word_cnt of A, sign-extended to DATA_SIZE.
    - word_cnt HALF..BUF_CYC-1: emit word (word_cnt-HALF) of B, sign-extended.
    - On the last word, pair_cnt++. If pair_cnt reaches SEQ_LEN/2, go to DRAIN; otherwise go to IDLE.
  - DRAIN: in_rdy=0 and mp_vld_in=0. Wait until out_cnt reaches SEQ_LEN/2, then go to IDLE and clear pair_cnt and out_cnt.
- out_cnt: increments on each mp_vld_out, in any state.
- frame_done: registered. Asserts the cycle after the mp_vld_out that makes out_cnt = SEQ_LEN/2.
- Sign extension: bits BW_IN..DATA_SIZE-1 of each padded sample equal the sample's bit BW_IN-1.
- mp_data_in: holds its last value while mp_vld_in=0.
- Maxpool latency is 3 cycles. The last result therefore arrives 3 cycles after the final word, and frame_done follows 1 cycle later.
- Throughput: one pair every BUF_CYC+2 cycles when upstream is always valid.
- Reset mid-frame: all state is discarded; a partly sent pair is not completed.

Optional Feature:
Macro MAXPOOL_SCHED_ERR_EN.
- When defined: err is set and held until reset if either of these occurs:
  - mp_vld_out arrives while out_cnt == pair_cnt, i.e. no pair is outstanding;
  - in_vld drops in WAIT_B before B is accepted, i.e. a mid-pair gap that breaks the upstream contract.
- When not defined: err is tied to 0 and no checking logic is built.

Test Plan (NO_CH=2, BW_IN=12, SER_BW=4, so BUF_CYC=8 and DATA_SIZE=16; SEQ_LEN=4):
1. Reset: hold rst=0 for 5 cycles with in_vld=1 -> in_rdy=0, mp_vld_in=0, busy=0. in_rdy goes high 1 cycle after release.
2. Serialization, ch0 A=-5 (0xFFB), B=7 -> 8 consecutive mp_vld_in words on ch0: B,F,F,F,7,0,0,0. in_rdy stays low throughout.
3. Full frame of samples 1,2,3,4 with a behavioural maxpool model -> two pairs issued, then DRAIN; out_cnt=2; frame_done pulses exactly once, 4 cycles after the 16th word; state returns to IDLE.
4. Upstream gaps: in_vld toggling 1/0 -> no words emitted until B is accepted; each burst is exactly 8 words long.
5. Async reset asserted at word 3 of SHIFT -> mp_vld_in drops immediately; the next frame restarts at pair_cnt=0.
6. With MAXPOOL_SCHED_ERR_EN defined, inject mp_vld_out while IDLE with no pair issued -> err=1 and it stays high until reset. Without the macro, the same stimulus gives err=0.

Source files
------------

// File: rtl/maxpool_sched_if.sv
// Handshake and serial-word bundle between the upstream conv layer, maxpool_sched
// and the serial maxpool stage.
interface maxpool_sched_if #(
  parameter int NO_CH  = 10,
  parameter int BW_IN  = 12,
  parameter int SER_BW = 4
);
  logic                             in_vld;
  logic                             in_rdy;
  logic [NO_CH-1:0][BW_IN-1:0]      in_data;
  logic                             mp_vld_in;
  logic [NO_CH-1:0][SER_BW-1:0]     mp_data_in;
  logic                             mp_vld_out;
  logic                             frame_done;
  logic                             busy;
  logic                             err;

  modport master (
    output in_vld, in_data, mp_vld_out,
    input  in_rdy, mp_vld_in, mp_data_in, frame_done, busy, err
  );

  modport slave (
    input  in_vld, in_data, mp_vld_out,
    output in_rdy, mp_vld_in, mp_data_in, frame_done, busy, err
  );
endinterface

// File: rtl/maxpool_sched.sv
// Pairs upstream samples and serializes each pair LS word first into the maxpool stage.
// Optional sticky protocol checker enabled by defining MAXPOOL_SCHED_ERR_EN.

// One channel: sign-extend A and B to DATA_SIZE and pick serial word sel of {B, A}.
module maxpool_sched_lane #(
  parameter int BW_IN     = 12,
  parameter int SER_BW    = 4,
  parameter int BUF_CYC   = 8,
  parameter int DATA_SIZE = 16
) (
  input  logic [BW_IN-1:0]           a,
  input  logic [BW_IN-1:0]           b,
  input  logic [$clog2(BUF_CYC)-1:0] sel,
  output logic [SER_BW-1:0]          word
);
  logic [1:0][DATA_SIZE-1:0]       ext;
  logic [BUF_CYC-1:0][SER_BW-1:0]  words;

  assign ext[0] = DATA_SIZE'($signed(a));
  assign ext[1] = DATA_SIZE'($signed(b));
  assign words  = ext;
  assign word   = words[sel];
endmodule

module maxpool_sched #(
  parameter int NO_CH   = 10,
  parameter int BW_IN   = 12,
  parameter int SER_BW  = 4,
  parameter int SEQ_LEN = 1024
) (
  input logic            clk,
  input logic            rst,
  maxpool_sched_if.slave bus
);
  localparam int BUF_CYC   = 2 << ($clog2(BW_IN) - $clog2(SER_BW));
  localparam int HALF      = BUF_CYC / 2;
  localparam int DATA_SIZE = HALF * SER_BW;
  localparam int WC_W      = $clog2(BUF_CYC);
  localparam int NPAIR     = SEQ_LEN / 2;
  localparam int CNT_W     = $clog2(NPAIR + 1);

  if (SEQ_LEN % 2 != 0) begin : g_bad_len
    $error("maxpool_sched: SEQ_LEN must be even");
  end

  typedef enum logic [1:0] {IDLE, WAIT_B, SHIFT, DRAIN} state_t;

  state_t                       state;
  logic [NO_CH-1:0][BW_IN-1:0]  a_q, b_q;
  logic [NO_CH-1:0][SER_BW-1:0] lane_word;
  logic [WC_W-1:0]              word_cnt, sel;
  logic [CNT_W-1:0]             pair_cnt, out_cnt;
  logic                         xfer;

  assign xfer = bus.in_vld && bus.in_rdy;
  // word_cnt tracks the word currently on the bus, so lanes prepare the next one
  assign sel  = (state == SHIFT) ? word_cnt + 1'b1 : '0;

  for (genvar c = 0; c < NO_CH; c++) begin : g_lane
    maxpool_sched_lane #(
      .BW_IN(BW_IN), .SER_BW(SER_BW), .BUF_CYC(BUF_CYC), .DATA_SIZE(DATA_SIZE)
    ) u_lane (
      .a(a_q[c]), .b(b_q[c]), .sel(sel), .word(lane_word[c])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      a_q            <= '0;
      b_q            <= '0;
      word_cnt       <= '0;
      pair_cnt       <= '0;
      out_cnt        <= '0;
      bus.in_rdy     <= 1'b0;
      bus.mp_vld_in  <= 1'b0;
      bus.mp_data_in <= '0;
      bus.frame_done <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      if (bus.mp_vld_out) out_cnt <= out_cnt + 1'b1;
      bus.frame_done <= bus.mp_vld_out && (out_cnt == CNT_W'(NPAIR - 1));
      case (state)
        IDLE: begin
          bus.in_rdy    <= 1'b1;
          bus.mp_vld_in <= 1'b0;
          if (xfer) begin
            a_q      <= bus.in_data;
            bus.busy <= 1'b1;
            state    <= WAIT_B;
          end
        end
        WAIT_B: begin
          // Word 0 only needs A, so it goes out on the same edge B is captured
          if (xfer) begin
            b_q            <= bus.in_data;
            bus.in_rdy     <= 1'b0;
            word_cnt       <= '0;
            bus.mp_vld_in  <= 1'b1;
            bus.mp_data_in <= lane_word;
            state          <= SHIFT;
          end
        end
        SHIFT: begin
          if (word_cnt == WC_W'(BUF_CYC - 1)) begin
            bus.mp_vld_in <= 1'b0;
            pair_cnt      <= pair_cnt + 1'b1;
            if (pair_cnt == CNT_W'(NPAIR - 1)) begin
              state <= DRAIN;
            end else begin
              bus.in_rdy <= 1'b1;
              bus.busy   <= 1'b0;
              state      <= IDLE;
            end
          end else begin
            word_cnt       <= word_cnt + 1'b1;
            bus.mp_data_in <= lane_word;
          end
        end
        DRAIN: begin
          bus.mp_vld_in <= 1'b0;
          if (out_cnt == CNT_W'(NPAIR)) begin
            pair_cnt   <= '0;
            out_cnt    <= '0;
            bus.in_rdy <= 1'b1;
            bus.busy   <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAXPOOL_SCHED_ERR_EN
  // Sticky: a result with nothing outstanding, or upstream stalling mid-pair
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bus.err <= 1'b0;
    else if ((bus.mp_vld_out && (out_cnt == pair_cnt)) || (state == WAIT_B && !bus.in_vld))
      bus.err <= 1'b1;
  end
`else
  assign bus.err = 1'b0;
`endif
endmodule
